vp_validation_queue: RTL

Feedback generator for the value predictor. Records each forwarded prediction in order, collects out-of-order execution results by queue index, and retires completed entries in program order. Retired entries drive the predictor's feedback interface (`fb_pc`, `fb_result`, `fb_valid`, `fb_mispredict`). Sits between the predictor's forward-prediction output and the backend's execution writeback.

---
 rtl/vp_validation_queue.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/vp_validation_queue.sv
// Value-prediction validation queue: records forwarded predictions in order, captures execution
// results out of order, and retires completed entries in order onto the predictor feedback port.
// Define VP_VALQ_STATS_EN to add saturating mispredict / retired-prediction counters.
module vp_validation_queue #(
  parameter int P_NUM_PRED    = 2,
  parameter int P_QUEUE_DEPTH = 16,
  parameter int P_IDX_W       = $clog2(P_QUEUE_DEPTH)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic [P_NUM_PRED-1:0]              enq_valid_i,
  input  logic [P_NUM_PRED-1:0][31:0]        enq_pc_i,
  input  logic [P_NUM_PRED-1:0][31:0]        enq_pred_i,
  input  logic [P_NUM_PRED-1:0]              enq_pred_valid_i,
  output logic                               enq_ready_o,
  output logic [P_NUM_PRED-1:0][P_IDX_W-1:0] enq_idx_o,
  input  logic [P_NUM_PRED-1:0]              ex_valid_i,
  input  logic [P_NUM_PRED-1:0][P_IDX_W-1:0] ex_idx_i,
  input  logic [P_NUM_PRED-1:0][31:0]        ex_result_i,
  output logic [P_NUM_PRED-1:0]              fb_valid_o,
  output logic [P_NUM_PRED-1:0][31:0]        fb_pc_o,
  output logic [P_NUM_PRED-1:0][31:0]        fb_result_o,
  output logic [P_NUM_PRED-1:0]              fb_mispredict_o,
  output logic [P_IDX_W:0]                   count_o
`ifdef VP_VALQ_STATS_EN
  ,
  output logic [31:0]                        stat_mispred_o,
  output logic [31:0]                        stat_retired_o
`endif
);

  localparam int                LP_CNT_W     = P_IDX_W + 1;
  localparam logic [P_IDX_W:0]  LP_READY_MAX = LP_CNT_W'(P_QUEUE_DEPTH - P_NUM_PRED);

  function automatic logic [LP_CNT_W-1:0] popcnt(input logic [P_NUM_PRED-1:0] v);
    logic [LP_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < P_NUM_PRED; i++) begin
      n = n + LP_CNT_W'(v[i]);
    end
    return n;
  endfunction

  logic [P_QUEUE_DEPTH-1:0] r_alloc;
  logic [P_QUEUE_DEPTH-1:0] r_done;
  logic [P_QUEUE_DEPTH-1:0] r_pred_valid;
  logic [31:0]              r_pc     [P_QUEUE_DEPTH];
  logic [31:0]              r_pred   [P_QUEUE_DEPTH];
  logic [31:0]              r_result [P_QUEUE_DEPTH];
  logic [P_IDX_W-1:0]       r_head;
  logic [P_IDX_W-1:0]       r_tail;
  logic [LP_CNT_W-1:0]      r_count;
  logic                     r_enq_ready;

  logic [P_NUM_PRED-1:0]              r_fb_valid;
  logic [P_NUM_PRED-1:0][31:0]        r_fb_pc;
  logic [P_NUM_PRED-1:0][31:0]        r_fb_result;
  logic [P_NUM_PRED-1:0]              r_fb_mis;

  logic [P_NUM_PRED-1:0][P_IDX_W-1:0] w_enq_idx;
  logic [P_NUM_PRED-1:0][P_IDX_W-1:0] w_ret_idx;
  logic [P_NUM_PRED-1:0]              w_ret;
  logic [P_NUM_PRED-1:0]              w_pv;
  logic [P_NUM_PRED-1:0]              w_mis;
  logic                               w_enq_fire;
  logic                               w_chain;
  logic [LP_CNT_W-1:0]                w_offs;
  logic [LP_CNT_W-1:0]                w_enq_n;
  logic [LP_CNT_W-1:0]                w_ret_n;
  logic [LP_CNT_W-1:0]                w_count_next;

  // Compact allocation: each valid lane takes tail plus the number of valid lanes below it.
  always_comb begin
    w_enq_fire = r_enq_ready & (|enq_valid_i);
    w_offs     = '0;
    for (int k = 0; k < P_NUM_PRED; k++) begin
      w_enq_idx[k] = r_tail + P_IDX_W'(w_offs);
      w_offs       = w_offs + LP_CNT_W'(enq_valid_i[k]);
    end
    if (w_enq_fire) begin
      w_enq_n = popcnt(enq_valid_i);
    end else begin
      w_enq_n = '0;
    end
  end

  // In-order retire chain from head; a flush suppresses retirement entirely.
  always_comb begin
    w_chain = ~flush_i;
    for (int j = 0; j < P_NUM_PRED; j++) begin
      w_ret_idx[j] = r_head + P_IDX_W'(j);
      w_ret[j]     = w_chain & r_alloc[w_ret_idx[j]] & r_done[w_ret_idx[j]];
      w_pv[j]      = r_pred_valid[w_ret_idx[j]];
      w_mis[j]     = w_pv[j] & (r_pred[w_ret_idx[j]] != r_result[w_ret_idx[j]]);
      w_chain      = w_ret[j];
    end
    w_ret_n      = popcnt(w_ret);
    w_count_next = r_count + w_enq_n - w_ret_n;
  end

  // Entry storage, pointers and occupancy; writeback, then retire-clear, then allocate.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_alloc      <= '0;
      r_done       <= '0;
      r_pred_valid <= '0;
      for (int e = 0; e < P_QUEUE_DEPTH; e++) begin
        r_pc[e]     <= 32'h0000_0000;
        r_pred[e]   <= 32'h0000_0000;
        r_result[e] <= 32'h0000_0000;
      end
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_enq_ready <= 1'b1;
    end else if (flush_i) begin
      r_alloc     <= '0;
      r_done      <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_enq_ready <= 1'b1;
    end else begin
      // Ascending lane order lets the higher lane win a duplicate-index writeback.
      for (int k = 0; k < P_NUM_PRED; k++) begin
        if (ex_valid_i[k] && r_alloc[ex_idx_i[k]]) begin
          r_result[ex_idx_i[k]] <= ex_result_i[k];
          r_done[ex_idx_i[k]]   <= 1'b1;
        end
      end
      for (int j = 0; j < P_NUM_PRED; j++) begin
        if (w_ret[j]) begin
          r_alloc[w_ret_idx[j]] <= 1'b0;
          r_done[w_ret_idx[j]]  <= 1'b0;
        end
      end
      if (w_enq_fire) begin
        for (int k = 0; k < P_NUM_PRED; k++) begin
          if (enq_valid_i[k]) begin
            r_alloc[w_enq_idx[k]]      <= 1'b1;
            r_done[w_enq_idx[k]]       <= 1'b0;
            r_pc[w_enq_idx[k]]         <= enq_pc_i[k];
            r_pred[w_enq_idx[k]]       <= enq_pred_i[k];
            r_pred_valid[w_enq_idx[k]] <= enq_pred_valid_i[k];
          end
        end
      end
      r_head      <= r_head + P_IDX_W'(w_ret_n);
      r_tail      <= r_tail + P_IDX_W'(w_enq_n);
      r_count     <= w_count_next;
      r_enq_ready <= (w_count_next <= LP_READY_MAX);
    end
  end

  // Feedback register: one cycle after the retire decision.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fb_valid  <= '0;
      r_fb_mis    <= '0;
      r_fb_pc     <= '0;
      r_fb_result <= '0;
    end else if (flush_i) begin
      r_fb_valid  <= '0;
      r_fb_mis    <= '0;
      r_fb_pc     <= '0;
      r_fb_result <= '0;
    end else begin
      for (int j = 0; j < P_NUM_PRED; j++) begin
        r_fb_valid[j] <= w_ret[j];
        r_fb_mis[j]   <= w_ret[j] & w_mis[j];
        if (w_ret[j]) begin
          r_fb_pc[j]     <= r_pc[w_ret_idx[j]];
          r_fb_result[j] <= r_result[w_ret_idx[j]];
        end
      end
    end
  end

`ifdef VP_VALQ_STATS_EN
  logic [31:0] r_stat_mis;
  logic [31:0] r_stat_ret;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [LP_CNT_W-1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Cumulative statistics; cleared only by reset, never by flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stat_mis <= 32'h0000_0000;
      r_stat_ret <= 32'h0000_0000;
    end else begin
      r_stat_mis <= sat_add(r_stat_mis, popcnt(w_ret & w_mis));
      r_stat_ret <= sat_add(r_stat_ret, popcnt(w_ret & w_pv));
    end
  end

  assign stat_mispred_o = r_stat_mis;
  assign stat_retired_o = r_stat_ret;
`endif

  assign enq_ready_o     = r_enq_ready;
  assign enq_idx_o       = w_enq_idx;
  assign count_o         = r_count;
  assign fb_valid_o      = r_fb_valid;
  assign fb_pc_o         = r_fb_pc;
  assign fb_result_o     = r_fb_result;
  assign fb_mispredict_o = r_fb_mis;

endmodule
